// File: rtl/multicycle_main_controller.sv
// RV32I main control: single-cycle opcode decode plus an FSM that
// sequences multi-cycle MEMCOPY and iterative MUL custom ops.
module multicycle_main_controller #(
  parameter int MUL_LATENCY    = 8,
  parameter int MAX_COPY_WORDS = 16,
  parameter int CNT_W          = $clog2(MAX_COPY_WORDS+1),
  localparam int SW            = $clog2(MUL_LATENCY+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [6:0]       Opcode,
  input  logic [CNT_W-1:0] copy_words,
  input  logic             mem_ready,
  output logic             ALUSrc,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             jump,
  output logic [1:0]       Aluop,
  output logic             MemCopy,
  output logic             mul,
  output logic             stall,
  output logic             busy,
  output logic [CNT_W-1:0] copy_idx,
  output logic [SW-1:0]    mul_step,
  output logic             illegal
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_MCP  = 7'b1000000;
  localparam logic [6:0] OP_MUL  = 7'b1111111;

  localparam logic [CNT_W-1:0] NMAX  = CNT_W'(MAX_COPY_WORDS);
  localparam logic [SW-1:0]    SLAST = SW'(MUL_LATENCY-1);

  // {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,jump,Aluop}
  localparam logic [9:0] C_R    = 10'b0_00_1_0_0_0_0_10;
  localparam logic [9:0] C_LW   = 10'b1_01_1_1_0_0_0_00;
  localparam logic [9:0] C_S    = 10'b1_00_0_0_1_0_0_00;
  localparam logic [9:0] C_SB   = 10'b0_00_0_0_0_1_0_01;
  localparam logic [9:0] C_I    = 10'b1_00_1_0_0_0_0_11;
  localparam logic [9:0] C_JALR = 10'b1_10_1_0_0_0_1_00;
  localparam logic [9:0] C_JAL  = 10'b0_10_1_0_0_0_1_00;
  localparam logic [9:0] C_RD   = 10'b0_00_0_1_0_0_0_00;
  localparam logic [9:0] C_WR   = 10'b0_00_0_0_1_0_0_00;
  localparam logic [9:0] C_MULW = 10'b0_11_1_0_0_0_0_00;

  typedef enum logic [1:0] {
    IDLE, CP_RD, CP_WR, MUL_RUN
  } state_t;

  state_t           state, nstate;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [SW-1:0]    step_q, step_d;
  logic [CNT_W-1:0] n_req;
  logic             cp_last;
  logic [9:0]       ctl;

  assign n_req   = (copy_words > NMAX) ? NMAX : copy_words;
  assign cp_last = (idx_q == n_q - CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      n_q    <= '0;
      idx_q  <= '0;
      step_q <= '0;
    end else begin
      state  <= nstate;
      n_q    <= n_d;
      idx_q  <= idx_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    nstate = state;
    n_d    = n_q;
    idx_d  = idx_q;
    step_d = step_q;
    unique case (state)
      IDLE: begin
        if (instr_valid && Opcode == OP_MCP && n_req != '0) begin
          nstate = CP_RD;
          n_d    = n_req;
          idx_d  = '0;
        end else if (instr_valid && Opcode == OP_MUL
                     && MUL_LATENCY > 1) begin
          nstate = MUL_RUN;
          step_d = SW'(1);
        end
      end
      CP_RD: begin
        if (mem_ready) nstate = CP_WR;
      end
      CP_WR: begin
        if (mem_ready && cp_last) begin
          nstate = IDLE;
          idx_d  = '0;
          n_d    = '0;
        end else if (mem_ready) begin
          nstate = CP_RD;
          idx_d  = idx_q + CNT_W'(1);
        end
      end
      MUL_RUN: begin
        if (step_q == SLAST) begin
          nstate = IDLE;
          step_d = '0;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Reset forces every strobe low even if the decode inputs are live
  always_comb begin
    ctl     = '0;
    MemCopy = 1'b0;
    mul     = 1'b0;
    stall   = 1'b0;
    illegal = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            unique case (1'b1)
              (Opcode == OP_R):    ctl = C_R;
              (Opcode == OP_LW):   ctl = C_LW;
              (Opcode == OP_S):    ctl = C_S;
              (Opcode == OP_SB):   ctl = C_SB;
              (Opcode == OP_I):    ctl = C_I;
              (Opcode == OP_JALR): ctl = C_JALR;
              (Opcode == OP_JAL):  ctl = C_JAL;
              (Opcode == OP_MCP):  stall = (n_req != '0);
              (Opcode == OP_MUL): begin
                mul = 1'b1;
                if (MUL_LATENCY == 1) ctl = C_MULW;
                else stall = 1'b1;
              end
              default: illegal = 1'b1;
            endcase
          end
        end
        CP_RD: begin
          ctl     = C_RD;
          MemCopy = 1'b1;
          stall   = 1'b1;
        end
        CP_WR: begin
          ctl     = C_WR;
          MemCopy = 1'b1;
          stall   = !(mem_ready && cp_last);
        end
        MUL_RUN: begin
          mul = 1'b1;
          if (step_q == SLAST) ctl = C_MULW;
          else stall = 1'b1;
        end
        default: ctl = '0;
      endcase
    end
  end

  assign {ALUSrc, MemtoReg, RegWrite, MemRead,
          MemWrite, Branch, jump, Aluop} = ctl;
  assign busy     = (state != IDLE);
  assign copy_idx = idx_q;
  assign mul_step = step_q;

endmodule
